digit_store: RTL and testbench
==============================

Name: digit_store

Overview:
- Operand digit buffer for the online multiplier. It sits directly downstream of the address counter.
- It captures a serial, MSD-first stream of radix-2 signed digits into a 512-entry store, tracked by an internal write pointer.
- It serves digits back to the datapath at the address the counter produces, with a hit flag.
- It asserts run once the online delay DELTA worth of digits has been received.

Parameters:
- ADDR_W, 9, address width; matches the 9-bit address counter output.
- DEPTH, 512, number of digit entries (2**ADDR_W).
- DELTA, 3, online delay in digits; run asserts once this many digits are stored.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin new operand frame; clears pointers.
- in_valid  in  1  input digit present.
- in_digit  in  2  signed digit encoding: 00=0, 01=+1, 11=-1, 10=illegal.
- in_last  in  1  marks final digit of frame; qualified by in_valid.
- in_ready  out  1  block accepts a digit this cycle.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address, driven by the address counter.
- rd_digit  out  2  read data.
- rd_hit  out  1  rd_digit holds a stored digit.
- wr_count  out  ADDR_W+1  digits stored in the current frame, range 0..512.
- run  out  1  wr_count >= DELTA, or frame done.
- done  out  1  last digit accepted.
- digit_err  out  1  sticky; illegal encoding seen.
- ovf_err  out  1  sticky; digit offered while store was full.

Behaviour:
- Reset: while rst_n=0, and asynchronously on assertion, the block clears state as follows.
  - State=IDLE.
  - wr_count=0; rd_digit=00; rd_hit=0.
  - in_ready, run, done, digit_err, ovf_err all 0.
  - Store contents are not reset. Hit gating makes stale data invisible.
- FSM states: IDLE, FILL, RUN, DONE.
  - IDLE: in_ready=0. start -> FILL.
  - FILL: in_ready = (wr_count<DEPTH). The accept that makes wr_count reach DELTA -> RUN.
  - RUN: same accept rule as FILL.
  - Accepting in_last from FILL or RUN -> DONE.
  - DONE: in_ready=0. Reads still serviced.
  - start in any state -> FILL next cycle. It clears wr_count, done and both error flags.
  - start has priority over a same-cycle in_valid; that digit is dropped.
- Write accept: in_valid & in_ready.
  - Write in_digit to entry wr_count[ADDR_W-1:0], then wr_count+1.
  - Illegal 10 is stored as 00 and sets digit_err.
- run: registered, equal to (state==RUN or state==DONE). It is high the cycle after the DELTA-th accept.
  - If in_last arrives before DELTA digits, the block goes straight to DONE and run=1.
- Full: at wr_count==DEPTH, in_ready=0.
  - in_valid=1 in FILL or RUN while full sets ovf_err. The digit is discarded and the count is unchanged.
- Read path, 1-cycle latency:
  - On rd_en, the block samples hit = (rd_addr < wr_count), using wr_count before any same-cycle write.
  - Next cycle: rd_hit=hit. rd_digit = stored digit if hit, else 00.
  - A read of the address being written in the same cycle returns a miss.
- rd_en=0: rd_hit=0 next cycle, rd_digit=00.
- Reads in IDLE always miss.
- Arithmetic: wr_count is ADDR_W+1 bits and saturates at DEPTH. It never wraps.

Decomposition:
- Shared package holds:
  - digit encodings DIG_ZERO=00, DIG_POS=01, DIG_NEG=11;
  - the FSM state enum;
  - ADDR_W and DEPTH.
- One sub-module: digit_ram.
  - DEPTH x 2 memory.
  - 1 synchronous write port, 1 registered read port.
  - No reset.
  - The top level holds the FSM, counters and hit gating.

Test Plan:
- Reset/idle: rst_n low, then high. Then in_valid=1, digit 01 -> in_ready=0, wr_count=0, all flags 0.
- Fill to run: start, then digits 01,11,00,01.
  - run rises the cycle after the 3rd accept.
  - wr_count=4.
  - Reads of addr 0..3 -> 01,11,00,01 with rd_hit=1.
  - Read of addr 4 -> rd_digit=00, rd_hit=0.
- Short frame: start, then digits 01 and 11 (with in_last).
  - done=1, run=1, in_ready=0, wr_count=2.
  - Further in_valid is ignored, with no ovf_err.
- Full/overflow: 512 digits with no last -> in_ready=0, wr_count=512. A 513th in_valid -> ovf_err=1, count still 512.
- Same-cycle read/write and illegal digit:
  - Write to addr 5 while reading addr 5 -> rd_hit=0.
  - Read addr 5 again next cycle -> hit.
  - Input 10 -> stored 00, digit_err=1.
- Async reset mid-frame: rst_n pulse at wr_count=100 -> all outputs 0 immediately. A subsequent read of addr 0 misses.

Source files
------------

// File: rtl/digit_store_pkg.sv
// Shared types and constants for the online-multiplier operand digit buffer.
// Holds the signed-digit encodings, the buffer FSM states and the address geometry.
package digit_store_pkg;

    localparam int ADDR_W = 9;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [1:0] digit_t;

    localparam digit_t DIG_ZERO = 2'b00;
    localparam digit_t DIG_POS  = 2'b01;
    localparam digit_t DIG_NEG  = 2'b11;
    localparam digit_t DIG_ILL  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic digit_is_legal(input digit_t d);
        return d != DIG_ILL;
    endfunction

endpackage

// File: rtl/digit_store_ram.sv
// DEPTH x 2 digit memory: one synchronous write port and one registered read port.
// No reset on purpose; the caller hides stale entries with its own hit flag.
module digit_ram
    import digit_store_pkg::*;
#(
    parameter int ADDR_W = digit_store_pkg::ADDR_W,
    parameter int DEPTH  = digit_store_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [1:0]        wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [1:0]        rd_data
);

    digit_t mem [DEPTH];
    digit_t rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/digit_store.sv
// Operand digit buffer: captures an MSD-first signed-digit frame, serves digits back
// by address with a hit flag, and raises run once the online delay has been filled.
module digit_store
    import digit_store_pkg::*;
#(
    parameter int ADDR_W = digit_store_pkg::ADDR_W,
    parameter int DEPTH  = digit_store_pkg::DEPTH,
    parameter int DELTA  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [1:0]        in_digit,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [1:0]        rd_digit,
    output logic              rd_hit,
    output logic [ADDR_W:0]   wr_count,
    output logic              run,
    output logic              done,
    output logic              digit_err,
    output logic              ovf_err
);

    typedef logic [ADDR_W:0] cnt_t;

    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
    localparam cnt_t DELTA_C = cnt_t'(DELTA);

    function automatic cnt_t sat_inc(input cnt_t c);
        return (c >= DEPTH_C) ? DEPTH_C : cnt_t'(c + cnt_t'(1));
    endfunction

    function automatic digit_t sanitize(input digit_t d);
        return digit_is_legal(d) ? d : DIG_ZERO;
    endfunction

    state_t state_q, state_d;
    cnt_t   wr_count_q, wr_count_d;
    logic   run_q, run_d;
    logic   done_q, done_d;
    logic   digit_err_q, digit_err_d;
    logic   ovf_err_q, ovf_err_d;
    logic   rd_hit_q, rd_hit_d;

    logic   frame_open;
    logic   not_full;
    logic   ready_c;
    logic   accept;
    digit_t ram_rd_data;

    assign frame_open = (state_q == ST_FILL) || (state_q == ST_RUN);
    assign not_full   = wr_count_q < DEPTH_C;
    // start wins over a same-cycle digit, so it also withdraws ready
    assign ready_c    = frame_open && not_full && !start;
    assign accept     = in_valid && ready_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_FILL;
        end else begin
            case (state_q)
                ST_FILL, ST_RUN: begin
                    if (accept) begin
                        if (in_last) begin
                            state_d = ST_DONE;
                        end else if (sat_inc(wr_count_q) >= DELTA_C) begin
                            state_d = ST_RUN;
                        end
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        wr_count_d  = wr_count_q;
        digit_err_d = digit_err_q;
        ovf_err_d   = ovf_err_q;
        if (start) begin
            wr_count_d  = '0;
            digit_err_d = 1'b0;
            ovf_err_d   = 1'b0;
        end else begin
            if (accept) begin
                wr_count_d = sat_inc(wr_count_q);
                if (!digit_is_legal(in_digit)) begin
                    digit_err_d = 1'b1;
                end
            end
            if (in_valid && frame_open && !not_full) begin
                ovf_err_d = 1'b1;
            end
        end
        run_d    = (state_d == ST_RUN) || (state_d == ST_DONE);
        done_d   = (state_d == ST_DONE);
        // hit uses the pre-write count, so a read of the slot being written misses
        rd_hit_d = rd_en && (state_q != ST_IDLE) && ({1'b0, rd_addr} < wr_count_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count_q  <= '0;
            run_q       <= 1'b0;
            done_q      <= 1'b0;
            digit_err_q <= 1'b0;
            ovf_err_q   <= 1'b0;
            rd_hit_q    <= 1'b0;
        end else begin
            wr_count_q  <= wr_count_d;
            run_q       <= run_d;
            done_q      <= done_d;
            digit_err_q <= digit_err_d;
            ovf_err_q   <= ovf_err_d;
            rd_hit_q    <= rd_hit_d;
        end
    end

    digit_ram #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (wr_count_q[ADDR_W-1:0]),
        .wr_data (sanitize(in_digit)),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (ram_rd_data)
    );

    always_comb begin
        in_ready  = ready_c;
        rd_hit    = rd_hit_q;
        rd_digit  = rd_hit_q ? ram_rd_data : DIG_ZERO;
        wr_count  = wr_count_q;
        run       = run_q;
        done      = done_q;
        digit_err = digit_err_q;
        ovf_err   = ovf_err_q;
    end

endmodule

// File: tb/tb_digit_store.sv
// Directed bench for digit_store: read responses go through an expectation queue
// checked by an independent monitor; status outputs are checked inline.
module tb_digit_store;

    localparam int ADDR_W = 9;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              in_valid;
    logic [1:0]        in_digit;
    logic              in_last;
    logic              in_ready;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [1:0]        rd_digit;
    logic              rd_hit;
    logic [ADDR_W:0]   wr_count;
    logic              run;
    logic              done;
    logic              digit_err;
    logic              ovf_err;

    digit_store dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_digit  (in_digit),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_digit  (rd_digit),
        .rd_hit    (rd_hit),
        .wr_count  (wr_count),
        .run       (run),
        .done      (done),
        .digit_err (digit_err),
        .ovf_err   (ovf_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic       hit;
        logic [1:0] dig;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] d, input logic last);
        in_valid = 1'b1;
        in_digit = d;
        in_last  = last;
        cyc();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic rd(input int addr, input logic hit, input logic [1:0] dig);
        rd_en   = 1'b1;
        rd_addr = ADDR_W'(addr);
        exp_q.push_back('{hit: hit, dig: dig});
        cyc();
        rd_en = 1'b0;
    endtask

    task automatic frame_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic chk_all_clear(input string tag);
        chk({tag, "_in_ready"},  in_ready,  0);
        chk({tag, "_wr_count"},  wr_count,  0);
        chk({tag, "_run"},       run,       0);
        chk({tag, "_done"},      done,      0);
        chk({tag, "_digit_err"}, digit_err, 0);
        chk({tag, "_ovf_err"},   ovf_err,   0);
        chk({tag, "_rd_hit"},    rd_hit,    0);
        chk({tag, "_rd_digit"},  rd_digit,  0);
    endtask

    // Read-response monitor
    initial begin : monitor
        logic    fired;
        rd_exp_t e;
        forever begin
            @(posedge clk);
            fired = rd_en;
            @(negedge clk);
            if (fired) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL rd_unexpected: read response with no expectation at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_hit", rd_hit, e.hit);
                    chk("rd_digit", rd_digit, e.dig);
                end
            end
        end
    end

    initial begin : stim
        int waited;
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_digit = 2'b00;
        in_last  = 1'b0;
        rd_en    = 1'b0;
        rd_addr  = '0;

        // Reset and idle behaviour
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_clear("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        in_valid = 1'b1;
        in_digit = 2'b01;
        cyc();
        cyc();
        chk_all_clear("idle");
        in_valid = 1'b0;

        // Fill to run
        frame_start();
        send(2'b01, 1'b0);
        send(2'b11, 1'b0);
        chk("fill_run_before", run, 0);
        send(2'b00, 1'b0);
        chk("fill_run_after3", run, 1);
        send(2'b01, 1'b0);
        chk("fill_wr_count", wr_count, 4);
        rd(0, 1'b1, 2'b01);
        rd(1, 1'b1, 2'b11);
        rd(2, 1'b1, 2'b00);
        rd(3, 1'b1, 2'b01);
        rd(4, 1'b0, 2'b00);

        // Short frame ending before the online delay
        frame_start();
        chk("short_wr_count_cleared", wr_count, 0);
        send(2'b01, 1'b0);
        send(2'b11, 1'b1);
        chk("short_done", done, 1);
        chk("short_run", run, 1);
        chk("short_in_ready", in_ready, 0);
        chk("short_wr_count", wr_count, 2);
        send(2'b01, 1'b0);
        chk("short_ignored_count", wr_count, 2);
        chk("short_no_ovf", ovf_err, 0);

        // Full store and overflow
        frame_start();
        chk("full_done_cleared", done, 0);
        in_valid = 1'b1;
        for (int i = 0; i < 512; i++) begin
            in_digit = (i % 2 == 1) ? 2'b01 : 2'b11;
            cyc();
        end
        in_valid = 1'b0;
        chk("full_in_ready", in_ready, 0);
        chk("full_wr_count", wr_count, 512);
        chk("full_no_ovf_yet", ovf_err, 0);
        send(2'b01, 1'b0);
        chk("ovf_err_set", ovf_err, 1);
        chk("ovf_wr_count", wr_count, 512);
        rd(511, 1'b1, 2'b01);
        rd(0, 1'b1, 2'b11);

        // Same-cycle read/write and illegal digit
        frame_start();
        chk("rw_ovf_cleared", ovf_err, 0);
        repeat (5) send(2'b01, 1'b0);
        in_valid = 1'b1;
        in_digit = 2'b11;
        rd(5, 1'b0, 2'b00);
        in_valid = 1'b0;
        chk("rw_wr_count", wr_count, 6);
        rd(5, 1'b1, 2'b11);
        send(2'b10, 1'b0);
        chk("illegal_digit_err", digit_err, 1);
        rd(6, 1'b1, 2'b00);

        // Asynchronous reset mid-frame
        frame_start();
        chk("async_digit_err_cleared", digit_err, 0);
        in_valid = 1'b1;
        in_digit = 2'b01;
        repeat (100) cyc();
        in_valid = 1'b0;
        chk("async_wr_count_100", wr_count, 100);
        rd(0, 1'b1, 2'b01);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk_all_clear("async");
        @(posedge clk);
        #1 rst_n = 1'b1;
        rd(0, 1'b0, 2'b00);

        waited = 0;
        while (exp_q.size() != 0 && waited < 10) begin
            cyc();
            waited++;
        end
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL rd_drain: %0d responses outstanding, expected 0", exp_q.size());
        end
        cyc();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
